// File: rtl/attn_pkg.sv
// Shared constants and state encoding for the attention instruction sequencer.
package attn_pkg;

    localparam int ADDR_W = 4;   // width of qkmem_add and pmem_add fields
    localparam int INST_W = 20;  // instruction word width
    localparam int CNT_W  = 8;   // per-state cycle counter width

    // Instruction word bit positions
    localparam int INST_SFP_WR2PMEM = 19;
    localparam int INST_SFP_DIV     = 18;
    localparam int INST_SFP_ACC     = 17;
    localparam int INST_OFIFO_RD    = 16;
    localparam int INST_QKADD_LSB   = 12;
    localparam int INST_PADD_LSB    = 8;
    localparam int INST_EXECUTE     = 7;
    localparam int INST_LOAD        = 6;
    localparam int INST_QMEM_RD     = 5;
    localparam int INST_QMEM_WR     = 4;
    localparam int INST_KMEM_RD     = 3;
    localparam int INST_KMEM_WR     = 2;
    localparam int INST_PMEM_RD     = 1;
    localparam int INST_PMEM_WR     = 0;

    // Job phases in the order they are visited
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        QWR    = 4'd1,
        KWR    = 4'd2,
        GAP    = 4'd3,
        KLOAD  = 4'd4,
        DRAIN1 = 4'd5,
        EXEC   = 4'd6,
        DRAIN2 = 4'd7,
        OFIFO  = 4'd8,
        ACC    = 4'd9,
        DIV    = 4'd10,
        FIN    = 4'd11
    } state_e;

endpackage

// File: rtl/attn_inst_encode.sv
// Combinational instruction decode: maps (state, counter, DIV row/sub-cycle,
// accepted beat) onto the 20-bit fullchip instruction word.
module attn_inst_encode
    import attn_pkg::*;
#(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int aw          = ADDR_W
) (
    input  state_e            state_i,
    input  logic [CNT_W-1:0]  k_i,
    input  logic [aw-1:0]     r_i,
    input  logic [1:0]        s_i,
    input  logic              beat_i,
    output logic [INST_W-1:0] inst_o
);

    localparam logic [CNT_W-1:0] C_CNT  = CNT_W'(col);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(total_cycle - 1);

    logic [aw-1:0]    qk_add;
    logic [aw-1:0]    p_add;
    logic [CNT_W-1:0] acc_row;
    logic [aw-1:0]    r_next;

    // ACC reads each pmem row twice, then sits on the last row
    assign acc_row = k_i >> 1;
    // DIV write-back address runs one row ahead; truncates to aw bits
    assign r_next  = r_i + aw'(1);

    // Per-state field decode; anything not set here stays 0
    always_comb begin
        inst_o = '0;
        qk_add = '0;
        p_add  = '0;
        case (state_i)
            QWR: begin
                if (beat_i) begin
                    inst_o[INST_QMEM_WR] = 1'b1;
                    qk_add               = k_i[aw-1:0];
                end
            end
            KWR: begin
                if (beat_i) begin
                    inst_o[INST_KMEM_WR] = 1'b1;
                    qk_add               = k_i[aw-1:0];
                end
            end
            KLOAD: begin
                inst_o[INST_LOAD] = 1'b1;
                // First and last cycles frame the load with no read
                if ((k_i != '0) && (k_i <= C_CNT)) begin
                    inst_o[INST_KMEM_RD] = 1'b1;
                    qk_add               = k_i[aw-1:0] - aw'(1);
                end
            end
            EXEC: begin
                inst_o[INST_EXECUTE] = 1'b1;
                inst_o[INST_QMEM_RD] = 1'b1;
                qk_add               = k_i[aw-1:0];
            end
            OFIFO: begin
                inst_o[INST_OFIFO_RD] = 1'b1;
                inst_o[INST_PMEM_WR]  = 1'b1;
                p_add                 = k_i[aw-1:0];
            end
            ACC: begin
                inst_o[INST_PMEM_RD] = 1'b1;
                inst_o[INST_SFP_ACC] = 1'b1;
                p_add = (acc_row > T_LAST) ? T_LAST[aw-1:0] : acc_row[aw-1:0];
            end
            DIV: begin
                if (k_i == '0) begin
                    inst_o[INST_SFP_DIV] = 1'b1;
                end else begin
                    inst_o[INST_PMEM_RD] = 1'b1;
                    // Cycles 1..3 prime the read pipe at address 0
                    if (k_i >= CNT_W'(4)) begin
                        inst_o[INST_SFP_WR2PMEM] = 1'b1;
                        case (s_i)
                            2'd0: begin
                                inst_o[INST_SFP_DIV] = 1'b1;
                                inst_o[INST_PMEM_WR] = 1'b1;
                                p_add                = r_i;
                            end
                            2'd1: begin
                                inst_o[INST_SFP_DIV] = 1'b1;
                                p_add                = r_next;
                            end
                            default: p_add = r_next;
                        endcase
                    end
                end
            end
            default: ;
        endcase
        inst_o[INST_QKADD_LSB +: ADDR_W] = ADDR_W'(qk_add);
        inst_o[INST_PADD_LSB +: ADDR_W]  = ADDR_W'(p_add);
    end

endmodule

// File: rtl/attn_seq_ctrl.sv
// Attention job sequencer: accepts Q/K vectors over valid/ready and emits the
// full registered instruction stream for one job per start pulse.
//
// Handshake: a beat transfers on any rising edge where in_valid && in_ready;
// in_ready is high only in QWR/KWR, depends on state alone, and the source may
// present or withdraw in_valid at will (no stall penalty, no beat is lost).
module attn_seq_ctrl
    import attn_pkg::*;
#(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int bw          = 8,
    parameter int pr          = 8,
    parameter int core        = 2,
    parameter int drain       = 10,
    parameter int aw          = ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [pr*bw*core-1:0]   mem_in,
    output logic [pr*bw*core-1:0]   mem_out,
    output logic [INST_W-1:0]       inst,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              phase
);

    localparam int MW = pr * bw * core;

    localparam logic [CNT_W-1:0] T_LAST   = CNT_W'(total_cycle - 1);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] KL_LAST  = CNT_W'(col + 1);
    localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(drain - 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(2 * total_cycle);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(4 * total_cycle + 7);

    state_e            state_q;
    state_e            state_nx;
    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  k_last;
    logic [INST_W-1:0] inst_q;
    logic [INST_W-1:0] inst_d;
    logic [MW-1:0]     mem_out_q;
    logic              done_q;
    logic              beat;
    logic              step;
    logic [aw+1:0]     div_j;

    assign in_ready = (state_q == QWR) || (state_q == KWR);
    assign beat     = in_ready & in_valid;
    // Write phases advance only on accepted beats; all others every cycle
    assign step     = in_ready ? in_valid : 1'b1;

    // DIV body after the 4 lead-in cycles splits into row r, sub-cycle s
    assign div_j    = k_q[aw+1:0] - (aw + 2)'(4);

    // Last counter value and successor for each timed state
    always_comb begin
        k_last   = '0;
        state_nx = IDLE;
        case (state_q)
            QWR:    begin k_last = T_LAST;   state_nx = KWR;    end
            KWR:    begin k_last = C_LAST;   state_nx = GAP;    end
            GAP:    begin k_last = CNT_W'(1); state_nx = KLOAD; end
            KLOAD:  begin k_last = KL_LAST;  state_nx = DRAIN1; end
            DRAIN1: begin k_last = D_LAST;   state_nx = EXEC;   end
            EXEC:   begin k_last = T_LAST;   state_nx = DRAIN2; end
            DRAIN2: begin k_last = D_LAST;   state_nx = OFIFO;  end
            OFIFO:  begin k_last = T_LAST;   state_nx = ACC;    end
            ACC:    begin k_last = ACC_LAST; state_nx = DIV;    end
            DIV:    begin k_last = DIV_LAST; state_nx = FIN;    end
            default: ;
        endcase
    end

    attn_inst_encode #(
        .total_cycle (total_cycle),
        .col         (col),
        .aw          (aw)
    ) u_encode (
        .state_i (state_q),
        .k_i     (k_q),
        .r_i     (div_j[aw+1:2]),
        .s_i     (div_j[1:0]),
        .beat_i  (beat),
        .inst_o  (inst_d)
    );

    // Sequencer FSM with registered inst/mem_out/done, one cycle behind state
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q   <= IDLE;
            k_q       <= '0;
            inst_q    <= '0;
            mem_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            inst_q <= inst_d;
            done_q <= (state_q == FIN);
            if (beat) begin
                mem_out_q <= mem_in;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= QWR;
                        k_q     <= '0;
                    end
                end
                default: begin
                    if (step) begin
                        if (k_q == k_last) begin
                            state_q <= state_nx;
                            k_q     <= '0;
                        end else begin
                            k_q <= k_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign inst    = inst_q;
    assign mem_out = mem_out_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
    assign phase   = state_q;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Bench for attn_seq_ctrl: phase-table reference of the instruction stream,
// queued per cycle and compared against the registered DUT outputs.
module tb_attn_seq_ctrl;

    localparam int T  = 8;
    localparam int C  = 8;
    localparam int D  = 10;
    localparam int MW = 128;

    localparam logic [19:0] F_WR2P = 20'h80000;
    localparam logic [19:0] F_DIV  = 20'h40000;
    localparam logic [19:0] F_ACC  = 20'h20000;
    localparam logic [19:0] F_OFR  = 20'h10000;
    localparam logic [19:0] F_EXE  = 20'h00080;
    localparam logic [19:0] F_LOAD = 20'h00040;
    localparam logic [19:0] F_QRD  = 20'h00020;
    localparam logic [19:0] F_QWR  = 20'h00010;
    localparam logic [19:0] F_KRD  = 20'h00008;
    localparam logic [19:0] F_KWR  = 20'h00004;
    localparam logic [19:0] F_PRD  = 20'h00002;
    localparam logic [19:0] F_PWR  = 20'h00001;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] mem_in;
    logic [MW-1:0] mem_out;
    logic [19:0]   inst;
    logic          busy;
    logic          done;
    logic [3:0]    phase;

    always #5 clk = ~clk;

    attn_seq_ctrl #(
        .total_cycle (T),
        .col         (C),
        .bw          (8),
        .pr          (8),
        .core        (2),
        .drain       (D),
        .aw          (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_in   (mem_in),
        .mem_out  (mem_out),
        .inst     (inst),
        .busy     (busy),
        .done     (done),
        .phase    (phase)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [19:0]   exp_q[$];
    logic [MW-1:0] exp_mo_q[$];
    bit            vin_q[$];
    logic [MW-1:0] din_q[$];
    bit            rdy_q[$];
    logic [MW-1:0] model_mo;
    logic [MW-1:0] job_mo;
    int            ofifo_lo;
    int            ofifo_hi;
    int            div_wr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] iw(input logic [19:0] flags, input int qk, input int pa);
        logic [19:0] w;
        w        = flags;
        w[15:12] = qk[3:0];
        w[11:8]  = pa[3:0];
        return w;
    endfunction

    function automatic logic [MW-1:0] rnd_vec(input int idx, input logic [7:0] tag);
        return {$urandom(), $urandom(), $urandom(), tag, 16'h0, 8'(idx)};
    endfunction

    function automatic void push_cyc(input bit v, input bit wr, input logic [19:0] ins,
                                     input logic [MW-1:0] d);
        vin_q.push_back(v);
        din_q.push_back(d);
        rdy_q.push_back(wr);
        exp_q.push_back(ins);
        if (wr && v) job_mo = d;
        exp_mo_q.push_back(job_mo);
    endfunction

    // ---------------- driver: stimulus + expected stream for one job ----------------
    task automatic build(input bit toggle);
        int b;
        int qc;
        bit v;
        exp_q.delete(); exp_mo_q.delete(); vin_q.delete(); din_q.delete(); rdy_q.delete();
        job_mo = model_mo;
        b  = 0;
        qc = 0;
        while (b < T) begin
            v = toggle ? (qc % 2 == 0) : 1'b1;
            push_cyc(v, 1'b1, v ? iw(F_QWR, b, 0) : 20'h0, rnd_vec(b, 8'h51));
            if (v) b++;
            qc++;
        end
        for (int k = 0; k < C; k++) push_cyc(1'b1, 1'b1, iw(F_KWR, k, 0), rnd_vec(k, 8'h4B));
        repeat (2) push_cyc(1'b1, 1'b0, 20'h0, rnd_vec(0, 8'h00));
        for (int k = 0; k <= C + 1; k++)
            push_cyc(1'b1, 1'b0, (k >= 1 && k <= C) ? iw(F_LOAD | F_KRD, k - 1, 0) : F_LOAD,
                     rnd_vec(k, 8'h00));
        repeat (D) push_cyc(1'b1, 1'b0, 20'h0, rnd_vec(0, 8'h00));
        for (int k = 0; k < T; k++) push_cyc(1'b1, 1'b0, iw(F_EXE | F_QRD, k, 0), rnd_vec(k, 8'h00));
        repeat (D) push_cyc(1'b1, 1'b0, 20'h0, rnd_vec(0, 8'h00));
        ofifo_lo = exp_q.size();
        for (int k = 0; k < T; k++) push_cyc(1'b1, 1'b0, iw(F_OFR | F_PWR, 0, k), rnd_vec(k, 8'h00));
        ofifo_hi = exp_q.size();
        for (int k = 0; k <= 2 * T; k++)
            push_cyc(1'b1, 1'b0, iw(F_PRD | F_ACC, 0, (k / 2 > T - 1) ? T - 1 : k / 2), rnd_vec(k, 8'h00));
        push_cyc(1'b1, 1'b0, F_DIV, rnd_vec(0, 8'h00));
        repeat (3) push_cyc(1'b1, 1'b0, F_PRD, rnd_vec(0, 8'h00));
        for (int r = 0; r <= T; r++) begin
            push_cyc(1'b1, 1'b0, iw(F_PRD | F_DIV | F_WR2P | F_PWR, 0, r), rnd_vec(r, 8'h00));
            push_cyc(1'b1, 1'b0, iw(F_PRD | F_DIV | F_WR2P, 0, r + 1), rnd_vec(r, 8'h00));
            push_cyc(1'b1, 1'b0, iw(F_PRD | F_WR2P, 0, r + 1), rnd_vec(r, 8'h00));
            push_cyc(1'b1, 1'b0, iw(F_PRD | F_WR2P, 0, r + 1), rnd_vec(r, 8'h00));
        end
        push_cyc(1'b1, 1'b0, 20'h0, rnd_vec(0, 8'h00));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_inst"}, inst, 20'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    task automatic run_job(input bit toggle, input int abort_at, input bit ofifo_start);
        int            n;
        bit            aborted;
        logic [19:0]   e;
        logic [MW-1:0] emo;
        build(toggle);
        n       = exp_q.size();
        div_wr  = 0;
        aborted = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        for (int c = 0; c < n; c++) begin
            in_valid = vin_q.pop_front();
            mem_in   = din_q.pop_front();
            start    = ofifo_start && (c >= ofifo_lo) && (c < ofifo_hi);
            abort    = (c == abort_at);
            check("in_ready", in_ready, rdy_q.pop_front());
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            e   = exp_q.pop_front();
            emo = exp_mo_q.pop_front();
            if (c == abort_at) begin
                check_idle("abort");
                check("abort_mem_out", mem_out, '0);
                model_mo = '0;
                aborted  = 1'b1;
                break;
            end
            check("inst", inst, e);
            check("mem_out", mem_out, emo);
            check("done", done, (c == n - 1));
            check("busy", busy, (c < n - 1));
            if (inst[19] && inst[0]) begin
                check("div_wr_addr", inst[11:8], div_wr);
                div_wr++;
            end
        end
        if (!aborted) begin
            check("div_wr_count", div_wr, 9);
            model_mo = job_mo;
        end
        repeat (5) begin
            @(posedge clk); #1;
            check_idle("post_job");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        mem_in   = '0;
        model_mo = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            check_idle("reset");
            check("reset_mem_out", mem_out, '0);
        end
        run_job(1'b0, -1, 1'b1);
        run_job(1'b1, -1, 1'b0);
        run_job(1'b0, 41, 1'b0);
        run_job(1'b0, -1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
